// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: combinational per-stage stall vector, registered flush/redirect,
// sticky MEM-timeout error and bubble/stall cycle counters.
module stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bbl,
  input  logic             ex_req,
  input  logic             ex_done,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             flush_req,
  input  logic [31:0]      flush_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] bbl_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, EX_WAIT, MEM_WAIT, FLUSH} state_t;

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_BBL = 6'b000111;
  localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             mem_err_q, mem_err_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] bbl_cnt_q, bbl_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [5:0]       stall_c;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    new_pc_d  = new_pc_q;
    stall_c   = '0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d  = FLUSH;
          new_pc_d = flush_pc;
        end else if (mem_req) begin
          state_d = MEM_WAIT;
          timer_d = '0;
          stall_c = STALL_MEM;
        end else if (ex_req) begin
          state_d = EX_WAIT;
          stall_c = STALL_EX;
        end else if (bbl) begin
          stall_c = STALL_BBL;
        end
      end
      EX_WAIT: begin
        stall_c = STALL_EX;
        if (ex_done) state_d = RUN;
      end
      MEM_WAIT: begin
        stall_c = STALL_MEM;
        timer_d = timer_q + 8'd1;
        // An ack in the timeout cycle completes the access cleanly.
        if (mem_ack) begin
          state_d = RUN;
        end else if (timer_q == TMO_LAST) begin
          state_d   = RUN;
          mem_err_d = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_req) new_pc_d = flush_pc;
        else           state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!rst) stall_c = '0;

    flush_d     = (state_d == FLUSH);
    busy_d      = (state_d != RUN);
    bbl_cnt_d   = bbl_cnt_q + ((stall_c == STALL_BBL) ? CNT_W'(1) : CNT_W'(0));
    stall_cnt_d = stall_cnt_q + ((stall_c != 6'b0) ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mem_err_q   <= 1'b0;
      new_pc_q    <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      bbl_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_err_q   <= mem_err_d;
      new_pc_q    <= new_pc_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      bbl_cnt_q   <= bbl_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall     = stall_c;
  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign mem_err   = mem_err_q;
  assign busy      = busy_q;
  assign bbl_cnt   = bbl_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush controller sitting directly downstream of the bubble checker in the five-stage MIPS core. It consumes the checker's `bbl` hazard flag together with multi-cycle requests from EX (divider) and MEM (data-memory handshake) and branch/exception flush requests. From these it produces the per-stage `stall` vector, a one-cycle `flush` pulse with its redirect PC, a MEM-timeout error flag and two performance counters.

## Interface

Parameters:
- `MEM_TIMEOUT`, default 255: maximum cycles in MEM_WAIT before `mem_err`; legal range 1..255.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `bbl`  in  1  load-use hazard from the bubble checker; valid at the rising edge.
- `ex_req`  in  1  EX starts a multi-cycle op; 1-cycle pulse.
- `ex_done`  in  1  EX multi-cycle result ready; 1-cycle pulse.
- `mem_req`  in  1  MEM issues a data access needing an ack; 1-cycle pulse.
- `mem_ack`  in  1  data memory completes the access; 1-cycle pulse.
- `flush_req`  in  1  taken branch/exception redirect.
- `flush_pc`  in  32  redirect target, sampled with `flush_req`.
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold the stage.
- `flush`  out  1  registered 1-cycle squash pulse for IF/ID/EX.
- `new_pc`  out  32  registered redirect PC, valid while `flush`=1.
- `mem_err`  out  1  sticky MEM-timeout flag; cleared only by reset.
- `busy`  out  1  1 whenever state ≠ RUN.
- `bbl_cnt`  out  CNT_W  number of cycles with a bubble inserted.
- `stall_cnt`  out  CNT_W  number of cycles with `stall`≠0.

## Operation

- States: RUN, EX_WAIT, MEM_WAIT, FLUSH.
- `stall` is combinational from state and inputs; everything else is registered.
- `stall` encoding:
  - MEM_WAIT, or `mem_req` in RUN: 6'b011111.
  - EX_WAIT, or `ex_req` in RUN: 6'b001111.
  - `bbl` in RUN with no EX/MEM request: 6'b000111, which holds PC/IF/ID and lets a bubble enter EX.
  - Otherwise 6'b000000.
  - Priority is MEM > EX > bbl. `bbl` is ignored outside RUN.
- RUN transitions:
  - `flush_req` → FLUSH. This has the highest priority and overrides `ex_req`, `mem_req` and `bbl`; `stall` is 0 that cycle.
  - `mem_req` → MEM_WAIT.
  - `ex_req` → EX_WAIT.
  - Otherwise stay in RUN.
- EX_WAIT: stay until `ex_done`, then go to RUN. `flush_req` in EX_WAIT is ignored. An `ex_done` arriving in RUN is ignored.
- MEM_WAIT:
  - An 8-bit timer loads 0 on entry and increments each cycle.
  - `mem_ack` → RUN.
  - If the timer reaches MEM_TIMEOUT-1 without `mem_ack`, set `mem_err`=1 and go to RUN.
  - `mem_ack` and timeout in the same cycle: ack wins, no error.
- FLUSH: lasts exactly one cycle with `flush`=1 and `new_pc`=captured `flush_pc`, `stall`=0; then RUN. A `flush_req` while in FLUSH re-captures `flush_pc` and stays in FLUSH.
- Counters:
  - `bbl_cnt` increments when `stall`==6'b000111.
  - `stall_cnt` increments when `stall`≠0.
  - Both wrap modulo 2^CNT_W.

## Timing

- Reset (`rst`=0, asynchronous) forces:
  - state=RUN, `flush`=0, `new_pc`=0, `mem_err`=0, `busy`=0, counters=0, timer=0.
  - `stall`=0 regardless of inputs.
- Reset asserted mid-EX_WAIT or mid-MEM_WAIT aborts immediately; no `mem_err`.
- Stall latency:
  - `bbl`, `ex_req` and `mem_req` raise `stall` in the same cycle they are seen.
  - Wait-state stalls hold until the cycle in which `ex_done`/`mem_ack` is sampled. `stall` is still asserted in that cycle and drops to 0 in the next cycle.
- `flush` is asserted in the cycle after `flush_req` is sampled and lasts 1 cycle.
- A persistent `bbl` with no other request yields 6'b000111 every cycle; no internal limit is applied.

## Test plan

- Reset: drive `rst`=0 mid-MEM_WAIT with `bbl`=1 → `stall`=0, `busy`=0, counters=0 immediately (no clock edge needed).
- Load-use: `bbl`=1 for 2 cycles in RUN → `stall`=6'b000111 both cycles, `bbl_cnt`=2, `stall_cnt`=2, state stays RUN.
- Divider: `ex_req` pulse, `ex_done` 5 cycles later → `stall`=6'b001111 for 6 cycles, then 0; `bbl`=1 during the wait does not change `stall` or `bbl_cnt`.
- MEM priority: `mem_req`, `ex_req` and `bbl` in the same cycle → `stall`=6'b011111, state MEM_WAIT; `mem_ack` after 3 cycles → RUN, `mem_err`=0.
- Timeout: MEM_TIMEOUT=4, `mem_req`, no ack → after 4 cycles `mem_err`=1 sticky, state RUN; repeat with ack on cycle 4 → `mem_err` stays 0.
- Flush: `flush_req`=1 with `flush_pc`=32'h0000_0040 and `bbl`=1 in RUN → `stall`=0 that cycle; next cycle `flush`=1 and `new_pc`=32'h40; following cycle `flush`=0.
